// File: rtl/trng_cal_pkg.sv
// Shared types and width helpers for the TRNG bias calibrator.
package trng_cal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DECIDE  = 2'd3
    } cal_state_e;

    function automatic int unsigned settle_cnt_w(input int unsigned settle_cyc);
        return (settle_cyc < 2) ? 1 : $clog2(settle_cyc + 1);
    endfunction

    function automatic int unsigned ones_cnt_w(input int unsigned win_log2);
        return win_log2 + 1;
    endfunction

    function automatic int unsigned idx_w(input int unsigned code_w);
        return (code_w > 1) ? $clog2(code_w) : 1;
    endfunction

endpackage

// File: rtl/window_counter.sv
// Counts ones in rnd_bit over a 2^WIN_LOG2-sample window.
module window_counter
    import trng_cal_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              rnd_bit,
    output logic [WIN_LOG2:0] ones,
    output logic              win_last_c
);

    localparam int unsigned CNT_W = ones_cnt_w(WIN_LOG2);

    logic [WIN_LOG2-1:0] win_cnt;

    // Ones counter is one bit wider than the window so an all-ones window never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones    <= '0;
            win_cnt <= '0;
        end else if (clr) begin
            ones    <= '0;
            win_cnt <= '0;
        end else if (en) begin
            ones    <= ones + CNT_W'(rnd_bit);
            win_cnt <= win_cnt + WIN_LOG2'(1);
        end
    end

    assign win_last_c = en && (win_cnt == '1);

endmodule

// File: rtl/trng_bias_cal.sv
// SAR calibrator: searches the VDAC bias code, MSB first, against a target ones-density.
module trng_bias_cal
    import trng_cal_pkg::*;
#(
    parameter int unsigned CODE_W     = 8,
    parameter int unsigned WIN_LOG2   = 10,
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned POLARITY   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [WIN_LOG2:0] target,
    input  logic              rnd_bit,
    output logic [CODE_W-1:0] vdac_code,
    output logic              busy,
    output logic              done,
    output logic [WIN_LOG2:0] last_count
);

    localparam int unsigned SET_W = settle_cnt_w(SETTLE_CYC);
    localparam int unsigned IDX_W = idx_w(CODE_W);
    localparam int unsigned CNT_W = ones_cnt_w(WIN_LOG2);

    cal_state_e         state, state_d;
    logic [CODE_W-1:0]  code_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               busy_d, done_d;
    logic [CNT_W-1:0]   last_d;

    logic               win_clr_c, win_en_c, win_last_c;
    logic [CNT_W-1:0]   ones;
    logic               abort_c, settle_last_c, keep_c, launch_c;

    assign abort_c       = (state != ST_IDLE) && !ena;
    assign launch_c      = start && ena;
    assign settle_last_c = (settle_q == SET_W'(SETTLE_CYC - 1));
    // Equality always clears the trial bit
    assign keep_c        = (POLARITY != 0) ? (ones < target) : (ones > target);

    window_counter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_window_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (win_clr_c),
        .en         (win_en_c),
        .rnd_bit    (rnd_bit),
        .ones       (ones),
        .win_last_c (win_last_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (abort_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (launch_c)      state_d = ST_SETTLE;
                ST_SETTLE:  if (settle_last_c) state_d = ST_MEASURE;
                ST_MEASURE: if (win_last_c)    state_d = ST_DECIDE;
                ST_DECIDE:  state_d = (idx_q == '0) ? ST_IDLE : ST_SETTLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values; trial bit decisions happen in DECIDE
    always_comb begin
        code_d    = vdac_code;
        idx_d     = idx_q;
        settle_d  = settle_q;
        busy_d    = busy;
        done_d    = done;
        last_d    = last_count;
        win_clr_c = 1'b0;
        win_en_c  = 1'b0;
        if (abort_c) begin
            code_d   = '0;
            idx_d    = '0;
            settle_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch_c) begin
                        done_d   = 1'b0;
                        busy_d   = 1'b1;
                        idx_d    = IDX_W'(CODE_W - 1);
                        code_d   = CODE_W'(1) << (CODE_W - 1);
                        settle_d = '0;
                    end
                end
                ST_SETTLE: begin
                    settle_d = settle_q + SET_W'(1);
                    if (settle_last_c) begin
                        settle_d  = '0;
                        win_clr_c = 1'b1;
                    end
                end
                ST_MEASURE: win_en_c = 1'b1;
                ST_DECIDE: begin
                    last_d = ones;
                    if (!keep_c) code_d[idx_q] = 1'b0;
                    if (idx_q != '0) begin
                        code_d[idx_q - IDX_W'(1)] = 1'b1;
                        idx_d    = idx_q - IDX_W'(1);
                        settle_d = '0;
                    end else begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vdac_code  <= '0;
            idx_q      <= '0;
            settle_q   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            last_count <= '0;
        end else begin
            vdac_code  <= code_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            busy       <= busy_d;
            done       <= done_d;
            last_count <= last_d;
        end
    end

endmodule

// File: tb/tb_trng_bias_cal.sv
// Directed bench for trng_bias_cal with a window-exact rnd_bit model.
module tb_trng_bias_cal;

    localparam int unsigned CODE_W     = 4;
    localparam int unsigned WIN_LOG2   = 4;
    localparam int unsigned SETTLE_CYC = 2;
    localparam int unsigned POLARITY   = 1;
    localparam int          LATENCY    = 77;
    localparam int          MAX_CYC    = 300;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic              start;
    logic [WIN_LOG2:0] target;
    logic              rnd_bit;
    logic [CODE_W-1:0] vdac_code;
    logic              busy;
    logic              done;
    logic [WIN_LOG2:0] last_count;

    logic [1:0]        rnd_mode;   // 0 = model, 1 = tied 0, 2 = tied 1
    logic [3:0]        phase;

    int tests_run;
    int tests_failed;
    int trials[$];

    trng_bias_cal #(
        .CODE_W     (CODE_W),
        .WIN_LOG2   (WIN_LOG2),
        .SETTLE_CYC (SETTLE_CYC),
        .POLARITY   (POLARITY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .target     (target),
        .rnd_bit    (rnd_bit),
        .vdac_code  (vdac_code),
        .busy       (busy),
        .done       (done),
        .last_count (last_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) phase <= phase + 4'd1;

    // Each 16-sample window holds exactly vdac_code ones
    assign rnd_bit = (rnd_mode == 2'd0) ? (phase < vdac_code) :
                     (rnd_mode == 2'd2);

    task automatic run_search(input int tgt, input int second_at, output int cycles);
        int n;
        n = 0;
        trials.delete();
        target = (WIN_LOG2+1)'(tgt);
        start  = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
            start = (n == second_at);
            if (busy && (trials.size() == 0 || int'(vdac_code) != trials[$]))
                trials.push_back(int'(vdac_code));
        end while (!done && n < MAX_CYC);
        tests_run++;
        if (!done) begin
            $display("FAIL search_timeout: done=%0b after %0d cycles, required 1 within %0d", done, n, MAX_CYC);
            tests_failed++;
        end
        cycles = n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; start = 1'b0; target = '0; rnd_mode = 2'd0; phase = '0;
        #12;
        tests_run++;
        if (vdac_code !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || last_count !== 5'd0) begin
            $display("FAIL reset_values: code=%0d busy=%0b done=%0b last=%0d, required 0/0/0/0",
                     vdac_code, busy, done, last_count);
            tests_failed++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        // start with ena low is ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || vdac_code !== 4'd0) begin
            $display("FAIL start_ena_low: busy=%0b code=%0d, required 0/0", busy, vdac_code);
            tests_failed++;
        end
        ena = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        int cyc;
        rnd_mode = 2'd0;
        run_search(10, -1, cyc);
        tests_run++;
        if (cyc != LATENCY) begin
            $display("FAIL nominal_latency: got %0d cycles, required %0d", cyc, LATENCY);
            tests_failed++;
        end
        tests_run++;
        if (trials.size() != 4 || trials[0] != 8 || trials[1] != 12 || trials[2] != 10 || trials[3] != 9) begin
            $display("FAIL nominal_trials: got %p, required 8 12 10 9", trials);
            tests_failed++;
        end
        tests_run++;
        if (vdac_code !== 4'd9 || last_count !== 5'd9 || busy !== 1'b0 || done !== 1'b1) begin
            $display("FAIL nominal_result: code=%0d last=%0d busy=%0b done=%0b, required 9/9/0/1",
                     vdac_code, last_count, busy, done);
            tests_failed++;
        end
    endtask

    task automatic test_extremes();
        int cyc;
        rnd_mode = 2'd1;
        run_search(1, -1, cyc);
        tests_run++;
        if (vdac_code !== 4'd15 || last_count !== 5'd0) begin
            $display("FAIL extreme_all_kept: code=%0d last=%0d, required 15/0", vdac_code, last_count);
            tests_failed++;
        end
        rnd_mode = 2'd2;
        run_search(16, -1, cyc);
        tests_run++;
        if (vdac_code !== 4'd0 || last_count !== 5'd16) begin
            $display("FAIL extreme_full_window: code=%0d last=%0d, required 0/16", vdac_code, last_count);
            tests_failed++;
        end
        rnd_mode = 2'd0;
    endtask

    task automatic test_equality();
        int cyc;
        run_search(8, -1, cyc);
        tests_run++;
        if (trials.size() < 2 || trials[1] != 4) begin
            $display("FAIL equality_clears_msb: got trials %p, required second trial 4", trials);
            tests_failed++;
        end
        tests_run++;
        if (vdac_code !== 4'd7) begin
            $display("FAIL equality_result: code=%0d, required 7", vdac_code);
            tests_failed++;
        end
    endtask

    task automatic test_abort();
        target = 5'd10;
        start  = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        tests_run++;
        if (busy !== 1'b1 || last_count !== 5'd8) begin
            $display("FAIL abort_pre: busy=%0b last=%0d, required 1/8", busy, last_count);
            tests_failed++;
        end
        ena = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || vdac_code !== 4'd0 || last_count !== 5'd8) begin
            $display("FAIL abort_outputs: busy=%0b done=%0b code=%0d last=%0d, required 0/0/0/8",
                     busy, done, vdac_code, last_count);
            tests_failed++;
        end
        ena = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_search(10, 20, cyc);
        tests_run++;
        if (cyc != LATENCY || vdac_code !== 4'd9) begin
            $display("FAIL ignored_start: cycles=%0d code=%0d, required %0d/9", cyc, vdac_code, LATENCY);
            tests_failed++;
        end
        tests_run++;
        if (trials.size() != 4 || trials[0] != 8 || trials[1] != 12 || trials[2] != 10 || trials[3] != 9) begin
            $display("FAIL ignored_start_trials: got %p, required 8 12 10 9", trials);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        target = 5'd10;
        start  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (vdac_code !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || last_count !== 5'd0) begin
            $display("FAIL reset_mid: code=%0d busy=%0b done=%0b last=%0d, required 0/0/0/0",
                     vdac_code, busy, done, last_count);
            tests_failed++;
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_search(5, -1, cyc);
        tests_run++;
        if (vdac_code !== 4'd4 || cyc != LATENCY) begin
            $display("FAIL reset_restart: code=%0d cycles=%0d, required 4/%0d", vdac_code, cyc, LATENCY);
            tests_failed++;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_nominal();
        test_extremes();
        test_equality();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
